// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Holds the funct3 operation encodings, the FSM state type and the
// operand-sign classification helpers used at accept time.
package mdu_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Divide-family ops (DIV, DIVU, REM, REMU).
    function automatic logic op_is_div(input mdu_op_e op);
        logic res;
        case (op)
            MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: res = 1'b1;
            default:                              res = 1'b0;
        endcase
        return res;
    endfunction

    // Operand a is treated as signed.
    function automatic logic op_a_signed(input mdu_op_e op);
        logic res;
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

    // Operand b is treated as signed.
    function automatic logic op_b_signed(input mdu_op_e op);
        logic res;
        case (op)
            MDU_MULH, MDU_DIV, MDU_REM: res = 1'b1;
            default:                    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit (quotient MSB) into the partial remainder,
// trial-subtracts the divisor and shifts the resulting quotient bit in.
// Relies on rem_in < div_in, so bit XLEN of the difference is the borrow.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] div_in,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shift_s;
    logic [XLEN:0] diff_s;

    // Trial subtract; keep the difference only when it does not borrow.
    always_comb begin
        shift_s = {rem_in, quo_in[XLEN-1]};
        diff_s  = shift_s - {1'b0, div_in};
        if (!diff_s[XLEN]) begin
            rem_out = diff_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shift_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit between register read and writeback.
// One op in flight: IDLE -> CALC (XLEN bit-steps) -> FIX -> DONE -> IDLE.
// Works on operand magnitudes and applies the result sign in FIX.
// Optional macro MDU_FAST_MUL_EN: multiplies use a single-cycle product
// and skip CALC; divides are unaffected.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN       = MDU_XLEN,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = MDU_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic                  busy
);

    mdu_state_e            state_r, state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    mdu_op_e               op_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  neg_r;
    logic                  special_r;
    logic [XLEN-1:0]       special_data_r;
    logic [2*XLEN-1:0]     acc_r;
    logic [XLEN-1:0]       opnd_r;
    logic                  wb_valid_r;
    logic [REG_ADDR_W-1:0] wb_addr_r;
    logic [XLEN-1:0]       wb_data_r;

    mdu_op_e               op_s;
    logic                  a_neg_s, b_neg_s;
    logic [XLEN-1:0]       a_mag_s, b_mag_s;
    logic                  div_zero_s, ovf_s, special_s;
    logic [XLEN-1:0]       special_val_s;
    logic                  neg_s, neg_init_s;
    logic                  fast_sel_s;
    logic [2*XLEN-1:0]     acc_init_s;
    logic [XLEN-1:0]       opnd_init_s;
    logic                  accept_s, hs_s;
    logic [XLEN:0]         msum_s;
    logic [2*XLEN-1:0]     mul_next_s;
    logic [XLEN-1:0]       div_rem_s, div_quo_s;
    logic [2*XLEN-1:0]     prod_s;
    logic [XLEN-1:0]       quo_s, rem_s, result_s;

    assign op_s     = mdu_op_e'(in_op);
    assign in_ready = (state_r == IDLE) && !flush;
    assign wb_valid = wb_valid_r && !flush;
    assign wb_addr  = wb_addr_r;
    assign wb_data  = wb_data_r;
    assign busy     = (state_r != IDLE);
    assign accept_s = in_valid && in_ready;
    assign hs_s     = wb_valid && wb_ready;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_prod_s;

    // Sign-extend per op so the low 2*XLEN bits of the product are exact.
    always_comb begin
        fast_a_s    = {{XLEN{op_a_signed(op_s) & rs1_data[XLEN-1]}}, rs1_data};
        fast_b_s    = {{XLEN{op_b_signed(op_s) & rs2_data[XLEN-1]}}, rs2_data};
        fast_prod_s = fast_a_s * fast_b_s;
    end

    assign fast_sel_s = !op_is_div(op_s);
`else
    assign fast_sel_s = 1'b0;
`endif

    // Accept-time decode: magnitudes, result sign and the special cases.
    always_comb begin
        a_neg_s    = op_a_signed(op_s) & rs1_data[XLEN-1];
        b_neg_s    = op_b_signed(op_s) & rs2_data[XLEN-1];
        a_mag_s    = a_neg_s ? -rs1_data : rs1_data;
        b_mag_s    = b_neg_s ? -rs2_data : rs2_data;
        div_zero_s = op_is_div(op_s) && (rs2_data == {XLEN{1'b0}});
        ovf_s      = ((op_s == MDU_DIV) || (op_s == MDU_REM)) &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (rs2_data == {XLEN{1'b1}});
        special_s  = div_zero_s || ovf_s;
        if (ovf_s) begin
            special_val_s = (op_s == MDU_DIV) ? rs1_data : {XLEN{1'b0}};
        end else begin
            case (op_s)
                MDU_REM, MDU_REMU: special_val_s = rs1_data;
                default:           special_val_s = {XLEN{1'b1}};
            endcase
        end
        case (op_s)
            MDU_MULH, MDU_DIV:   neg_s = a_neg_s ^ b_neg_s;
            MDU_MULHSU, MDU_REM: neg_s = a_neg_s;
            default:             neg_s = 1'b0;
        endcase
        if (op_is_div(op_s)) begin
            acc_init_s  = {{XLEN{1'b0}}, a_mag_s};
            opnd_init_s = b_mag_s;
            neg_init_s  = neg_s;
        end else begin
`ifdef MDU_FAST_MUL_EN
            acc_init_s  = fast_prod_s;
            neg_init_s  = 1'b0;
`else
            acc_init_s  = {{XLEN{1'b0}}, b_mag_s};
            neg_init_s  = neg_s;
`endif
            opnd_init_s = a_mag_s;
        end
    end

    // Shift-add multiply step: add multiplicand on multiplier LSB, shift right.
    always_comb begin
        msum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
        if (acc_r[0]) begin
            mul_next_s = {msum_s, acc_r[XLEN-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[2*XLEN-1:1]};
        end
    end

    mdu_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (acc_r[2*XLEN-1:XLEN]),
        .quo_in  (acc_r[XLEN-1:0]),
        .div_in  (opnd_r),
        .rem_out (div_rem_s),
        .quo_out (div_quo_s)
    );

    // Sign correction and result selection used in FIX.
    always_comb begin
        prod_s = neg_r ? -acc_r : acc_r;
        quo_s  = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        rem_s  = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        if (special_r) begin
            result_s = special_data_r;
        end else begin
            case (op_r)
                MDU_MUL:                         result_s = prod_s[XLEN-1:0];
                MDU_MULH, MDU_MULHSU, MDU_MULHU: result_s = prod_s[2*XLEN-1:XLEN];
                MDU_DIV, MDU_DIVU:               result_s = quo_s;
                MDU_REM, MDU_REMU:               result_s = rem_s;
                default:                         result_s = prod_s[XLEN-1:0];
            endcase
        end
    end

    // FSM next-state: flush returns to IDLE from every state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (in_valid) begin
                    state_next_s = (special_s || fast_sel_s) ? FIX : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_W'(XLEN - 1)) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            DONE: begin
                if (flush || hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture, iteration, result load and writeback hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r          <= {CNT_W{1'b0}};
            op_r           <= MDU_MUL;
            rd_r           <= {REG_ADDR_W{1'b0}};
            neg_r          <= 1'b0;
            special_r      <= 1'b0;
            special_data_r <= {XLEN{1'b0}};
            acc_r          <= {(2*XLEN){1'b0}};
            opnd_r         <= {XLEN{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_addr_r      <= {REG_ADDR_W{1'b0}};
            wb_data_r      <= {XLEN{1'b0}};
        end else if (flush) begin
            wb_valid_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r           <= op_s;
                        rd_r           <= rd_addr;
                        neg_r          <= neg_init_s;
                        special_r      <= special_s;
                        special_data_r <= special_val_s;
                        acc_r          <= acc_init_s;
                        opnd_r         <= opnd_init_s;
                        cnt_r          <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    if (op_is_div(op_r)) begin
                        acc_r <= {div_rem_s, div_quo_s};
                    end else begin
                        acc_r <= mul_next_s;
                    end
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    wb_data_r  <= result_s;
                    wb_addr_r  <= rd_r;
                    wb_valid_r <= 1'b1;
                end
                DONE: begin
                    if (hs_s) begin
                        wb_valid_r <= 1'b0;
                    end
                end
                default: begin
                    wb_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M vectors, randomized ops
// against an arithmetic reference model, backpressure, flush and reset.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  rd;
    } vec_t;

    mdu_iter dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 32'd0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = (sa * sb) >>> 32; r = p[31:0]; end
            3'd2: begin p = (sa * ub) >>> 32; r = p[31:0]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from accept edge to wb_valid rising.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (op >= 3'd4) && ((b == 32'd0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        if (special) return 1;
`ifdef MDU_FAST_MUL_EN
        if (op < 3'd4) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present one op, then wait for wb_valid; inputs are scrambled after accept.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output logic [31:0] data, output logic [4:0] addr,
                            output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0; data = 32'd0; addr = 5'd0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; rs1_data = a; rs2_data = b; rd_addr = rd;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (wb_valid) break;
        end
        if (!wb_valid) to = 1'b1;
        data = wb_data;
        addr = wb_addr;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== 32'd0 || wb_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b data=%h addr=%h want 0 0 0 0", wb_valid, busy, wb_data, wb_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic check_op(input string name, input int idx, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        logic [31:0] d;
        logic [4:0]  ad;
        int          lat;
        bit          to;
        issue_op(op, a, b, rd, d, ad, lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s[%0d] timeout got no wb_valid want wb_valid", name, idx);
        end
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s[%0d] data op=%0d a=%h b=%h got %h want %h", name, idx, op, a, b, d, exp);
        end
        checks++;
        if (ad !== rd) begin
            errors++;
            $display("FAIL %s[%0d] addr got %0d want %0d", name, idx, ad, rd);
        end
        checks++;
        if (lat != exp_lat(op, a, b)) begin
            errors++;
            $display("FAIL %s[%0d] latency op=%0d got %0d want %0d", name, idx, op, lat, exp_lat(op, a, b));
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d] idle_after_hs got valid=%b busy=%b want 0 0", name, idx, wb_valid, busy);
        end
    endtask

    task automatic test_directed();
        vec_t v [14];
        v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5};
        v[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd1};
        v[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 5'd2};
        v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 5'd3};
        v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 5'd4};
        v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 5'd6};
        v[6]  = '{3'd5, 32'd100,        32'd7,         32'h0000_000E, 5'd7};
        v[7]  = '{3'd7, 32'd100,        32'd7,         32'h0000_0002, 5'd0};
        v[8]  = '{3'd4, 32'h1234,       32'd0,         32'hFFFF_FFFF, 5'd8};
        v[9]  = '{3'd6, 32'h1234,       32'd0,         32'h0000_1234, 5'd9};
        v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 5'd10};
        v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 5'd11};
        v[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 5'd31};
        v[13] = '{3'd7, 32'd5,          32'd0,         32'h0000_0005, 5'd30};
        for (int i = 0; i < 14; i++) begin
            check_op("directed", i, v[i].op, v[i].a, v[i].b, v[i].rd, v[i].exp);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            check_op("random", i, op, a, b, rd, ref_model(op, a, b));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, a, b;
        logic [4:0]  ad;
        int          lat;
        bit          to;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        wb_ready = 1'b0;
        issue_op(3'd5, a, b, 5'd17, d, ad, lat, to);
        checks++;
        if (to || d !== ref_model(3'd5, a, b)) begin
            errors++;
            $display("FAIL bp_result got %h (timeout=%b) want %h", d, to, ref_model(3'd5, a, b));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== d || wb_addr !== 5'd17 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%h addr=%0d in_ready=%b busy=%b want 1 %h 17 0 1",
                         i, wb_valid, wb_data, wb_addr, in_ready, busy, d);
            end
        end
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got valid=%b busy=%b in_ready=%b want 0 0 1", wb_valid, busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int          lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 99));
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd3; rs1_data = a1; rs2_data = b1; rd_addr = 5'd12;
        @(posedge clk);
        #1;
        in_op = 3'd7; rs1_data = a2; rs2_data = b2; rd_addr = 5'd13;
        lat = 0;
        while (lat < 100 && !wb_valid) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checks++;
        if (wb_data !== ref_model(3'd3, a1, b1) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got data=%h in_ready=%b want %h 0", wb_data, in_ready, ref_model(3'd3, a1, b1));
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got valid=%b in_ready=%b want 0 1", wb_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100 && !wb_valid) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== ref_model(3'd7, a2, b2) || wb_addr !== 5'd13) begin
            errors++;
            $display("FAIL b2b_second got valid=%b data=%h addr=%0d want 1 %h 13", wb_valid, wb_data, wb_addr,
                     ref_model(3'd7, a2, b2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic [4:0]  ad;
        int          lat;
        bit          to, seen;
        // flush in CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_pre got busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_idle got busy=%b valid=%b want 0 0", busy, wb_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (wb_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_no_result got wb_valid seen=%b want 0", seen);
        end
        // flush in DONE with wb_ready high: no handshake, valid gated low
        wb_ready = 1'b0;
        issue_op(3'd4, 32'hFFFF_FF00, 32'd0, 5'd9, d, ad, lat, to);
        @(negedge clk);
        flush = 1'b1;
        wb_ready = 1'b1;
        #1;
        checks++;
        if (to || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_gate got valid=%b (timeout=%b) want 0", wb_valid, to);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_idle got busy=%b valid=%b want 0 0", busy, wb_valid);
        end
        // flush in IDLE drops a concurrent request
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd5; rs1_data = 32'd9; rs2_data = 32'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        seen = busy;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (wb_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_drop got activity=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; rs1_data = 32'd77777; rs2_data = 32'd5; rd_addr = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got valid=%b data=%h busy=%b want 0 0 0", wb_valid, wb_data, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready got %b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
